// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: fetch PC, imem credit, in-flight PC FIFO, fetch queue; optional FETCH_BYPASS_EN
module fetch_unit #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                FQ_DEPTH  = 4,
    parameter int                MAX_OUTST = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc4
);

    localparam int QAW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int PAW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW  = $clog2(FQ_DEPTH) + 2;

    localparam logic [CW-1:0]     FQ_DEPTH_C  = CW'(FQ_DEPTH);
    localparam logic [CW-1:0]     MAX_OUTST_C = CW'(MAX_OUTST);
    localparam logic [PAW-1:0]    PF_LAST     = PAW'(MAX_OUTST - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK   = ~ADDR_W'(3);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [CW-1:0]     fq_cnt_q, fq_cnt_d;
    logic [QAW-1:0]    fq_head_q, fq_head_d;
    logic [QAW-1:0]    fq_tail_q, fq_tail_d;
    logic [PAW-1:0]    pf_head_q, pf_head_d;
    logic [PAW-1:0]    pf_tail_q, pf_tail_d;

    logic [31:0]       fq_inst_mem [FQ_DEPTH];
    logic [ADDR_W-1:0] fq_pc_mem   [FQ_DEPTH];
    logic [ADDR_W-1:0] pf_pc_mem   [MAX_OUTST];

    logic              issue;
    logic              rsp_keep;
    logic              bypass;
    logic              fq_empty;
    logic              fq_push;
    logic              fq_pop;
    logic [ADDR_W-1:0] rsp_pc;

    // Request credit, response classification, queue push/pop decisions and decode-side outputs.
    always_comb begin
        fq_empty       = (fq_cnt_q == '0);
        imem_req_valid = !rst && !redirect_valid && (outst_q < MAX_OUTST_C)
                         && ((outst_q + fq_cnt_q) < FQ_DEPTH_C);
        imem_req_addr  = fetch_pc_q & WORD_MASK;
        issue          = imem_req_valid && imem_req_ready;
        rsp_pc         = pf_pc_mem[pf_head_q];
        // A response is stale if it belongs to a request made before a redirect.
        rsp_keep       = imem_rsp_valid && !redirect_valid && (drop_q == '0);
`ifdef FETCH_BYPASS_EN
        bypass         = !rst && fq_empty && rsp_keep;
`else
        bypass         = 1'b0;
`endif
        fq_push        = rsp_keep && !(bypass && id_ready);
        fq_pop         = !fq_empty && id_ready && !redirect_valid;

        id_valid = !fq_empty || bypass;
        id_inst  = '0;
        id_pc    = '0;
        id_pc4   = '0;
        if (!fq_empty) begin
            id_inst = fq_inst_mem[fq_head_q];
            id_pc   = fq_pc_mem[fq_head_q];
        end else if (bypass) begin
            id_inst = imem_rsp_data;
            id_pc   = rsp_pc;
        end
        if (id_valid) begin
            id_pc4 = id_pc + ADDR_W'(4);
        end
    end

    // Next-state for fetch PC, outstanding/drop counters, queue and in-flight PC FIFO pointers.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q + CW'(issue) - CW'(imem_rsp_valid);
        drop_d     = drop_q;
        fq_head_d  = fq_head_q;
        fq_tail_d  = fq_tail_q;
        fq_cnt_d   = fq_cnt_q;
        pf_head_d  = pf_head_q;
        pf_tail_d  = pf_tail_q;

        // The in-flight PC FIFO tracks every request, stale or not, so it pops on every response.
        if (issue) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            pf_tail_d  = (pf_tail_q == PF_LAST) ? '0 : pf_tail_q + PAW'(1);
        end
        if (imem_rsp_valid) begin
            pf_head_d = (pf_head_q == PF_LAST) ? '0 : pf_head_q + PAW'(1);
        end

        if (redirect_valid) begin
            // Everything still in flight after this cycle is stale; a response arriving now is discarded too.
            fetch_pc_d = redirect_pc & WORD_MASK;
            drop_d     = outst_q - CW'(imem_rsp_valid);
            fq_head_d  = '0;
            fq_tail_d  = '0;
            fq_cnt_d   = '0;
        end else begin
            if (imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (fq_push) begin
                fq_tail_d = fq_tail_q + QAW'(1);
            end
            if (fq_pop) begin
                fq_head_d = fq_head_q + QAW'(1);
            end
            fq_cnt_d = fq_cnt_q + CW'(fq_push) - CW'(fq_pop);
        end
    end

    // Control state; reset returns the stage to empty and idle at RESET_PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC & WORD_MASK;
            outst_q    <= '0;
            drop_q     <= '0;
            fq_cnt_q   <= '0;
            fq_head_q  <= '0;
            fq_tail_q  <= '0;
            pf_head_q  <= '0;
            pf_tail_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            fq_cnt_q   <= fq_cnt_d;
            fq_head_q  <= fq_head_d;
            fq_tail_q  <= fq_tail_d;
            pf_head_q  <= pf_head_d;
            pf_tail_q  <= pf_tail_d;
        end
    end

    // Queue and in-flight PC storage; contents only matter behind the valid pointers.
    always_ff @(posedge clk) begin
        if (issue) begin
            pf_pc_mem[pf_tail_q] <= fetch_pc_q;
        end
        if (fq_push) begin
            fq_inst_mem[fq_tail_q] <= imem_rsp_data;
            fq_pc_mem[fq_tail_q]   <= rsp_pc;
        end
    end

endmodule
